// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM port between instruction fetch and data access,
// with flush-safe draining of an in-flight fetch and a bus watchdog.
module sram_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS, DRAIN} state_t;
    state_t     state;
    logic       last_data;
    logic [7:0] wdog;
    logic [7:0] wdog_n;
    logic       if_ok;
    logic       d_ok;
    logic       pick_d;
    logic       expire;
    logic       done;
    // A request whose ack is still showing is the one just served, not a new one.
    always_comb begin
        if_ok  = if_req & ~flush & ~if_ack;
        d_ok   = d_req & ~d_ack;
        pick_d = d_ok & ~(if_ok & last_data);
        wdog_n = wdog + 8'd1;
        expire = (state != IDLE) && !bus_ack && (wdog_n == 8'(TIMEOUT));
        done   = (state != IDLE) && (bus_ack || expire);
    end
    assign stallreq_if  = if_req & ~if_ack;
    assign stallreq_mem = d_req & ~d_ack;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_data <= 1'b0;
            wdog      <= 8'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= 4'd0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_err   <= 1'b0;
            if_ack    <= 1'b0;
            if_rdata  <= 32'd0;
            d_ack     <= 1'b0;
            d_rdata   <= 32'd0;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            if (state == IDLE) begin
                wdog <= 8'd0;
                if (if_ok || d_ok) begin
                    state     <= pick_d ? DACCESS : IFETCH;
                    bus_req   <= 1'b1;
                    bus_we    <= pick_d & d_we;
                    bus_sel   <= pick_d ? d_sel : 4'hF;
                    bus_addr  <= pick_d ? d_addr : if_addr;
                    bus_wdata <= pick_d ? d_wdata : 32'd0;
                end
            end else if (done) begin
                state     <= IDLE;
                bus_req   <= 1'b0;
                bus_err   <= expire;
                last_data <= state == DACCESS;
                if (state == DACCESS) begin
                    d_ack   <= 1'b1;
                    d_rdata <= bus_rdata & {32{~expire}};
                end else if (state == IFETCH && !flush) begin
                    if_ack   <= 1'b1;
                    if_rdata <= bus_rdata & {32{~expire}};
                end
            end else begin
                wdog <= wdog_n;
                if (state == IFETCH && flush)
                    state <= DRAIN;
            end
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed scenarios plus random traffic checked against a
// transaction-level reference model of the arbiter.
module tb_sram_bus_arbiter;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        rst, flush, if_req, d_req, d_we, bus_ack;
    logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
    logic [3:0]  d_sel;
    logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic        if_ack, d_ack, stallreq_if, stallreq_mem, bus_req, bus_we, bus_err;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          m_busy, m_data, m_discard, m_last_data;
    int          m_wait;
    logic        e_bus_req, e_bus_we, e_if_ack, e_d_ack, e_bus_err;
    logic [3:0]  e_bus_sel;
    logic [31:0] e_bus_addr, e_bus_wdata, e_if_rdata, e_d_rdata;

    sram_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // One transaction at a time: who owns the bus, how long it has waited,
    // and whether a flush has made its result worthless.
    task automatic model_step();
        bit prev_if_ack, prev_d_ack, want_i, want_d, err;
        if (rst) begin
            m_busy = 0; m_last_data = 0; m_discard = 0; m_wait = 0;
            e_bus_req = 0; e_bus_we = 0; e_bus_sel = 0; e_bus_addr = 0; e_bus_wdata = 0;
            e_if_ack = 0; e_d_ack = 0; e_bus_err = 0; e_if_rdata = 0; e_d_rdata = 0;
            return;
        end
        prev_if_ack = e_if_ack;
        prev_d_ack = e_d_ack;
        e_if_ack = 0; e_d_ack = 0; e_bus_err = 0;
        if (!m_busy) begin
            want_i = if_req && !flush && !prev_if_ack;
            want_d = d_req && !prev_d_ack;
            if (want_i || want_d) begin
                m_data = want_d && !(want_i && m_last_data);
                m_busy = 1; m_discard = 0; m_wait = 0;
                e_bus_req = 1;
                e_bus_we = m_data ? d_we : 1'b0;
                e_bus_sel = m_data ? d_sel : 4'hF;
                e_bus_addr = m_data ? d_addr : if_addr;
                e_bus_wdata = m_data ? d_wdata : 32'd0;
            end
        end else begin
            if (!m_data && flush) m_discard = 1;
            if (bus_ack || m_wait + 1 == TO) begin
                err = !bus_ack;
                m_busy = 0; e_bus_req = 0; e_bus_err = err; m_last_data = m_data;
                if (m_data) begin
                    e_d_ack = 1; e_d_rdata = err ? 32'd0 : bus_rdata;
                end else if (!m_discard) begin
                    e_if_ack = 1; e_if_rdata = err ? 32'd0 : bus_rdata;
                end
            end else m_wait++;
        end
    endtask

    task automatic compare();
        check("bus_req", 32'(bus_req), 32'(e_bus_req));
        check("bus_err", 32'(bus_err), 32'(e_bus_err));
        check("if_ack", 32'(if_ack), 32'(e_if_ack));
        check("d_ack", 32'(d_ack), 32'(e_d_ack));
        check("stallreq_if", 32'(stallreq_if), 32'(if_req & ~e_if_ack));
        check("stallreq_mem", 32'(stallreq_mem), 32'(d_req & ~e_d_ack));
        if (e_bus_req) begin
            check("bus_we", 32'(bus_we), 32'(e_bus_we));
            check("bus_sel", 32'(bus_sel), 32'(e_bus_sel));
            check("bus_addr", bus_addr, e_bus_addr);
            check("bus_wdata", bus_wdata, e_bus_wdata);
        end
        if (e_if_ack) check("if_rdata", if_rdata, e_if_rdata);
        if (e_d_ack) check("d_rdata", d_rdata, e_d_rdata);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; if_req = 0; d_req = 0; bus_ack = 0;
        cycle();
        rst = 0;
    endtask

    initial begin
        bit q[$];
        logic prev;
        logic [31:0] hold_addr;
        rst = 1; flush = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_sel = 0;
        d_addr = 0; d_wdata = 0; bus_ack = 0; bus_rdata = 0;
        cycle();
        cycle();
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        rst = 0;

        // zero-wait fetch
        if_req = 1; if_addr = 32'h0000_0100;
        cycle();
        check("zw_stall", 32'(stallreq_if), 32'd1);
        check("zw_addr", bus_addr, 32'h0000_0100);
        bus_ack = 1; bus_rdata = 32'h2408_0001;
        cycle();
        check("zw_ack", 32'(if_ack), 32'd1);
        check("zw_rdata", if_rdata, 32'h2408_0001);
        if_req = 0; bus_ack = 0;
        cycle();

        // contention: data first, fetch right after d_ack
        do_reset();
        if_req = 1; if_addr = 32'h0000_0400;
        d_req = 1; d_we = 1; d_sel = 4'b0011; d_addr = 32'h8000_0010; d_wdata = 32'hCAFE_0042;
        cycle();
        check("ct_we", 32'(bus_we), 32'd1);
        check("ct_sel", 32'(bus_sel), 32'h3);
        check("ct_addr", bus_addr, 32'h8000_0010);
        bus_ack = 1;
        cycle();
        check("ct_dack", 32'(d_ack), 32'd1);
        d_req = 0; bus_ack = 0;
        cycle();
        check("ct_fetch_req", 32'(bus_req), 32'd1);
        check("ct_fetch_addr", bus_addr, 32'h0000_0400);
        bus_ack = 1;
        cycle();
        check("ct_iack", 32'(if_ack), 32'd1);
        if_req = 0; bus_ack = 0;
        cycle();

        // starvation guard: both held, grants alternate
        do_reset();
        if_req = 1; if_addr = 32'h0000_0200;
        d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h8000_0020;
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus_req && !prev) q.push_back(bus_addr == d_addr);
            prev = bus_req;
            bus_ack = e_bus_req;
        end
        check("sv_count", 32'(q.size() >= 3), 32'd1);
        check("sv_g0_data", 32'(q[0]), 32'd1);
        check("sv_g1_fetch", 32'(q[1]), 32'd0);
        check("sv_g2_data", 32'(q[2]), 32'd1);

        // flush mid-fetch drains without if_ack
        do_reset();
        if_req = 1; if_addr = 32'h0000_0800;
        cycle();
        hold_addr = bus_addr;
        flush = 1;
        cycle();
        flush = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("fl_held", 32'(bus_req), 32'd1);
            check("fl_stable", bus_addr, hold_addr);
        end
        bus_ack = 1; bus_rdata = 32'h1234_5678; if_req = 0;
        cycle();
        check("fl_no_ack", 32'(if_ack), 32'd0);
        check("fl_released", 32'(bus_req), 32'd0);
        bus_ack = 0;
        cycle();

        // watchdog abort of a data access
        do_reset();
        d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h8000_0100; bus_rdata = 32'hDEAD_BEEF;
        cycle();
        for (int i = 0; i < TO - 1; i++) cycle();
        check("to_not_yet", 32'(bus_err), 32'd0);
        cycle();
        check("to_err", 32'(bus_err), 32'd1);
        check("to_dack", 32'(d_ack), 32'd1);
        check("to_rdata", d_rdata, 32'd0);
        d_req = 0;
        cycle();
        check("to_err_pulse", 32'(bus_err), 32'd0);

        // reset mid-access: bus released, no ack
        d_req = 1;
        cycle();
        cycle();
        rst = 1;
        cycle();
        check("ra_req", 32'(bus_req), 32'd0);
        check("ra_dack", 32'(d_ack), 32'd0);
        rst = 0; d_req = 0;
        cycle();
        check("ra_dack2", 32'(d_ack), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 299) == 0;
            flush = $urandom_range(0, 7) == 0;
            if (!if_req || e_if_ack) begin
                if_req = $urandom_range(0, 2) != 0;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req || e_d_ack) begin
                d_req = $urandom_range(0, 1) != 0;
                d_we = 1'($urandom_range(0, 1));
                d_sel = 4'($urandom_range(1, 15));
                d_addr = $urandom;
                d_wdata = $urandom;
            end
            bus_ack = e_bus_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            bus_rdata = $urandom;
            cycle();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_bus_arbiter.md
SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles bus_req may wait for bus_ack before abort (legal 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  pipeline flush from the pipeline controller; cancels instruction fetch.
REQ-005 SHALL have ports if_req input 1 and if_addr input 32: fetch request, held until if_ack.
REQ-006 SHALL have ports if_rdata output 32 and if_ack output 1: fetched word, valid only while if_ack=1.
REQ-007 SHALL have ports d_req input 1, d_we input 1, d_sel input 4, d_addr input 32, d_wdata input 32: data request, held until d_ack.
REQ-008 SHALL have ports d_rdata output 32 and d_ack output 1: load data, valid only while d_ack=1.
REQ-009 SHALL have ports stallreq_if output 1 and stallreq_mem output 1: stall requests to the pipeline controller.
REQ-010 SHALL have ports bus_req output 1, bus_we output 1, bus_sel output 4, bus_addr output 32, bus_wdata output 32: shared memory port.
REQ-011 SHALL have ports bus_rdata input 32, bus_ack input 1 (one-cycle completion strobe) and bus_err output 1 (timeout pulse).

Function
REQ-012 SHALL implement FSM states IDLE, IFETCH, DACCESS, DRAIN; all bus_* outputs, if_ack, d_ack, if_rdata, d_rdata, bus_err registered.
REQ-013 IDLE: SHALL grant by priority data > fetch, except fetch wins when both pending and last_grant=data (starvation guard).
REQ-014 IDLE: SHALL ignore if_req while flush=1 and ignore any request whose ack output is 1 in the same cycle (stale request).
REQ-015 On grant, the next cycle SHALL drive bus_req=1 with the latched address/we/sel/wdata (fetch: bus_we=0, bus_sel=4'hF, bus_wdata=0); bus outputs SHALL stay stable until bus_ack is sampled.
REQ-016 IFETCH/DACCESS: bus_ack=1 SHALL drop bus_req next cycle, pulse if_ack/d_ack for exactly one cycle with bus_rdata captured, update last_grant, and return to IDLE.
REQ-017 Minimum latency: request sampled at cycle t, zero-wait bus_ack at t+1 -> ack pulse at t+2.
REQ-018 IFETCH with flush=1 and bus_ack=0: SHALL go to DRAIN; bus request stays asserted unchanged (no abandonment).
REQ-019 DRAIN: on bus_ack SHALL return to IDLE with no if_ack; IFETCH with flush=1 and bus_ack=1 same cycle SHALL likewise discard (no if_ack).
REQ-020 flush SHALL NOT affect DACCESS; the data access completes normally.
REQ-021 Watchdog: 8-bit counter cleared on grant, incremented each cycle bus_req=1 without bus_ack; on reaching TIMEOUT SHALL drop bus_req, pulse bus_err one cycle, pulse the owner's ack with rdata=0 (no ack if DRAIN), return to IDLE.
REQ-022 stallreq_if SHALL be combinational if_req & ~if_ack; stallreq_mem SHALL be d_req & ~d_ack.
REQ-023 bus_ack arriving in IDLE SHALL be ignored.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, last_grant=fetch, watchdog=0, all registered outputs 0, regardless of transaction in progress; no ack issued for an aborted transfer.
REQ-025 rst SHALL take priority over flush, bus_ack and all requests.

Verification
REQ-026 Zero-wait fetch: if_req=1, if_addr=0x0000_0100, bus_ack next cycle with bus_rdata=0x2408_0001 -> if_ack=1, if_rdata=0x2408_0001 at t+2; stallreq_if high t..t+1.
REQ-027 Contention: if_req and d_req (d_we=1, d_sel=4'b0011, d_addr=0x8000_0010) same cycle -> data granted first with bus_we=1, bus_sel=4'b0011; fetch granted immediately after d_ack.
REQ-028 Starvation: d_req held continuously, if_req held -> grants alternate data, fetch, data.
REQ-029 Flush mid-fetch: flush=1 while IFETCH, bus_ack 3 cycles later -> DRAIN, no if_ack, bus_req held stable until ack, then IDLE.
REQ-030 Timeout: TIMEOUT=4, bus_ack never asserted in DACCESS -> bus_err pulse and d_ack with d_rdata=0 after 4 waiting cycles; rst asserted mid-DACCESS -> bus_req=0 next cycle, no d_ack.
